tc_to_signmag_serial: RTL

//   Bit-serial decoder from two's complement to sign-magnitude. It is the reverse of the

---
 rtl/tc_to_signmag_serial.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tc_to_signmag_serial.sv
// tc_to_signmag_serial
// Bit-serial two's complement to sign-magnitude decoder. The operand is walked
// LSB-first, one bit per clock. For a negative operand, bits are copied up to and
// including the first 1, and every later bit is inverted. The result is handed out
// over a valid/ready handshake and held until it is consumed.
module tc_to_signmag_serial #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_is_min,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] mag_r;
  logic             sign_r;
  logic             seen_one_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept_s;
  logic             last_s;
  logic             magbit_s;
  logic [WIDTH-1:0] mag_next_s;
  logic             is_min_s;

  // Serial conversion step: invert only after the first 1 of a negative operand.
  always_comb begin
    last_s     = (cnt_r == LAST_CNT);
    magbit_s   = shreg_r[0] ^ (sign_r & seen_one_r);
    mag_next_s = {magbit_s, mag_r[WIDTH-1:1]};
    // Only the most negative operand decodes to sign=1 with magnitude 100..0.
    is_min_s   = sign_r & (mag_next_s == MIN_MAG);
  end

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s  = SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift datapath and registered result/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r    <= {WIDTH{1'b0}};
      mag_r      <= {WIDTH{1'b0}};
      sign_r     <= 1'b0;
      seen_one_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      out_sign   <= 1'b0;
      out_mag    <= {WIDTH{1'b0}};
      out_is_min <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      busy      <= (state_s != IDLE);
      out_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shreg_r    <= in_data;
            sign_r     <= in_data[WIDTH-1];
            seen_one_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          mag_r      <= mag_next_s;
          shreg_r    <= {1'b0, shreg_r[WIDTH-1:1]};
          seen_one_r <= seen_one_r | shreg_r[0];
          cnt_r      <= cnt_r + CNT_ONE;
          if (last_s) begin
            out_sign   <= sign_r;
            out_mag    <= mag_next_s;
            out_is_min <= is_min_s;
          end
        end
        DONE: begin
          // Result registers simply hold; out_valid follows state_s above.
        end
        default: begin
          shreg_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule
